// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU step/clock front-end: mode encodings
// and button index assignments.
package cpu_ctrl_pkg;

   // Controller state, also driven straight out on MODE for the display path.
   typedef enum logic [1:0] {
      MODE_STEP   = 2'd0,
      MODE_RUN    = 2'd1,
      MODE_HALTED = 2'd2,
      MODE_CPURST = 2'd3
   } mode_e;

   // Button positions on the BTN bus.
   localparam int BTN_STEP = 0;
   localparam int BTN_RST  = 1;
   localparam int NUM_BTN  = 2;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// One board button: 2-flop synchroniser, polarity normalisation,
// stability counter and a registered one-cycle press pulse.
module btn_debounce #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press
);

   // Raw pin level of a released button; the synchroniser resets to it so
   // coming out of reset never looks like a press.
   localparam logic        IDLE_RAW = ACTIVE_LOW;
   localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

   logic        sync1_q;
   logic        sync2_q;
   logic        pressed_s;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic        db_q;
   logic        db_d;
   logic        db_prev_q;
   logic        press_q;
   logic        press_d;

   // Two-stage synchroniser for the asynchronous pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= IDLE_RAW;
         sync2_q <= IDLE_RAW;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // After synchronisation, 1 always means pressed.
   assign pressed_s = sync2_q ^ ACTIVE_LOW;

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
   always_comb begin
      cnt_d   = cnt_q;
      db_d    = db_q;
      press_d = db_q & ~db_prev_q;
      if (pressed_s == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_d  = pressed_s;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Debounce state and the edge-detect history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         press_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_q;
         press_q   <= press_d;
      end
   end

   assign btn_level = db_q;
   assign btn_press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock/step front-end for the 4-bit CPU: debounced single-step, free-run
// divider, halt handling and a timed CPU reset pulse. All outputs registered.
module cpu_step_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] RUN_DIV         = 24'd5000000,
   parameter logic [3:0]  RST_HOLD        = 4'd8,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       CLK1,
   input  logic       RST_N,
   input  logic [1:0] BTN,
   input  logic       RUN_SW,
   input  logic       HALT,
   output logic       STEP_EN,
   output logic       CPU_RST,
   output logic [7:0] STEP_CNT,
   output logic [1:0] MODE,
   output logic [1:0] BTN_DB
);

   localparam logic [23:0] DIV_LAST = RUN_DIV - 24'd1;

   logic [NUM_BTN-1:0] btn_db;
   logic [NUM_BTN-1:0] btn_press;
   logic               run_sync1_q;
   logic               run_sync2_q;

   mode_e       state_q;
   mode_e       state_d;
   logic        step_en_q;
   logic        step_en_d;
   logic        cpu_rst_q;
   logic        cpu_rst_d;
   logic [7:0]  step_cnt_q;
   logic [7:0]  step_cnt_d;
   logic [23:0] div_q;
   logic [23:0] div_d;
   logic [3:0]  hold_q;
   logic [3:0]  hold_d;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (BTN_ACTIVE_LOW)
         ) u_debounce (
            .clk       (CLK1),
            .rst_n     (RST_N),
            .btn_raw   (BTN[gi]),
            .btn_level (btn_db[gi]),
            .btn_press (btn_press[gi])
         );
      end
   endgenerate

   // Synchronise the run/step switch; reset level is step mode.
   always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) begin
         run_sync1_q <= 1'b0;
         run_sync2_q <= 1'b0;
      end else begin
         run_sync1_q <= RUN_SW;
         run_sync2_q <= run_sync1_q;
      end
   end

   // Next-state and registered-output logic; a reset press overrides everything.
   always_comb begin
      state_d    = state_q;
      step_en_d  = 1'b0;
      cpu_rst_d  = 1'b0;
      step_cnt_d = step_cnt_q;
      div_d      = div_q;
      hold_d     = hold_q;
      if (btn_press[BTN_RST]) begin
         state_d    = MODE_CPURST;
         cpu_rst_d  = 1'b1;
         hold_d     = RST_HOLD;
         step_cnt_d = '0;
         div_d      = '0;
      end else begin
         case (state_q)
            MODE_STEP: begin
               if (HALT) begin
                  state_d = MODE_HALTED;
               end else begin
                  if (btn_press[BTN_STEP]) begin
                     step_en_d  = 1'b1;
                     step_cnt_d = step_cnt_q + 8'd1;
                  end
                  if (run_sync2_q) begin
                     state_d = MODE_RUN;
                     div_d   = '0;
                  end
               end
            end
            MODE_RUN: begin
               if (HALT) begin
                  state_d = MODE_HALTED;
               end else if (!run_sync2_q) begin
                  state_d = MODE_STEP;
               end else if (div_q == DIV_LAST) begin
                  step_en_d  = 1'b1;
                  step_cnt_d = step_cnt_q + 8'd1;
                  div_d      = '0;
               end else begin
                  div_d = div_q + 24'd1;
               end
            end
            MODE_CPURST: begin
               // hold_q counts the CPU_RST cycles still to be shown, including this one.
               if (hold_q > 4'd1) begin
                  cpu_rst_d = 1'b1;
                  hold_d    = hold_q - 4'd1;
               end else begin
                  hold_d  = '0;
                  state_d = run_sync2_q ? MODE_RUN : MODE_STEP;
               end
            end
            default: begin
               // Halted: only a reset press (handled above) leaves this state.
               state_d = MODE_HALTED;
            end
         endcase
      end
   end

   // Controller state, counters and output registers.
   always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= MODE_STEP;
         step_en_q  <= 1'b0;
         cpu_rst_q  <= 1'b0;
         step_cnt_q <= '0;
         div_q      <= '0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         step_en_q  <= step_en_d;
         cpu_rst_q  <= cpu_rst_d;
         step_cnt_q <= step_cnt_d;
         div_q      <= div_d;
         hold_q     <= hold_d;
      end
   end

   assign STEP_EN  = step_en_q;
   assign CPU_RST  = cpu_rst_q;
   assign STEP_CNT = step_cnt_q;
   assign MODE     = state_q;
   assign BTN_DB   = btn_db;

endmodule
